// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan path: digit-select codes,
// capture states and the digit index type.
package display_pkg;

  localparam logic [3:0] AN_D0    = 4'b1110;
  localparam logic [3:0] AN_D1    = 4'b1101;
  localparam logic [3:0] AN_D2    = 4'b1011;
  localparam logic [3:0] AN_D3    = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef enum logic {HUNT, COLLECT} scan_state_t;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/an_decode.sv
// Maps an active-low digit-select code to a digit index, flagging the blank
// code and every code that selects zero or several digits.
module an_decode
  import display_pkg::*;
(
  input  logic [3:0] an,
  output digit_idx_t idx,
  output logic       blank,
  output logic       illegal
);

  always_comb begin
    idx     = 2'd0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (an)
      AN_D0:    idx = 2'd0;
      AN_D1:    idx = 2'd1;
      AN_D2:    idx = 2'd2;
      AN_D3:    idx = 2'd3;
      AN_BLANK: blank = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_scan_capture.sv
// Rebuilds complete hex/point/LE frames from the multiplexed display scan bus
// and hands them out on a valid/ready port with overrun tracking.
module display_scan_capture
  import display_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [3:0]  Hexout,
  input  logic        LE,
  input  logic        p,
  input  logic        frame_ready,
  output logic [15:0] hexout_frame,
  output logic [3:0]  point_frame,
  output logic [3:0]  le_frame,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        overrun
);

  logic [3:0]  s_an;
  logic [3:0]  s_hex;
  logic        s_le;
  logic        s_p;
  logic [7:0]  stable_cnt;
  logic        accepted;
  logic        changed;
  logic        accept;

  digit_idx_t  idx;
  logic        blank;
  logic        illegal;

  scan_state_t state_q;
  scan_state_t state_d;
  digit_idx_t  exp_q;
  digit_idx_t  exp_d;
  logic        store;
  logic        complete;
  logic        err;

  logic [15:0] stage_hex;
  logic [3:0]  stage_pt;
  logic [3:0]  stage_le;
  logic [15:0] commit_hex;
  logic [3:0]  commit_pt;
  logic [3:0]  commit_le;

  // The change test looks at the incoming value so the count restarts at 1
  // on the very edge that captures a new sample.
  assign changed = {AN, Hexout, LE, p} != {s_an, s_hex, s_le, s_p};
  assign accept  = (stable_cnt == 8'(STABLE_CYCLES)) && !accepted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an       <= 4'd0;
      s_hex      <= 4'd0;
      s_le       <= 1'b0;
      s_p        <= 1'b0;
      stable_cnt <= 8'd0;
      accepted   <= 1'b0;
    end else begin
      s_an  <= AN;
      s_hex <= Hexout;
      s_le  <= LE;
      s_p   <= p;
      if (changed) begin
        stable_cnt <= 8'd1;
        accepted   <= 1'b0;
      end else begin
        if (stable_cnt != 8'(STABLE_CYCLES)) stable_cnt <= stable_cnt + 8'd1;
        if (accept) accepted <= 1'b1;
      end
    end
  end

  an_decode u_an_decode (
    .an      (s_an),
    .idx     (idx),
    .blank   (blank),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      exp_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    store    = 1'b0;
    complete = 1'b0;
    err      = 1'b0;
    if (accept && !blank) begin
      if (illegal) begin
        err     = 1'b1;
        state_d = HUNT;
      end else begin
        case (state_q)
          HUNT: begin
            if (idx == 2'd0) begin
              store   = 1'b1;
              exp_d   = 2'd1;
              state_d = COLLECT;
            end
          end
          COLLECT: begin
            if (idx == exp_q) begin
              store = 1'b1;
              if (exp_q == 2'd3) begin
                complete = 1'b1;
                state_d  = HUNT;
              end else begin
                exp_d = exp_q + 2'd1;
              end
            end else begin
              err = 1'b1;
              // An early digit 0 is taken as the start of a fresh frame.
              if (idx == 2'd0) begin
                store = 1'b1;
                exp_d = 2'd1;
              end else begin
                state_d = HUNT;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  // Staging merged with the digit being accepted; this is what a completing
  // frame publishes, since digit 3 lands on the same edge as the commit.
  always_comb begin
    commit_hex = stage_hex;
    commit_pt  = stage_pt;
    commit_le  = stage_le;
    commit_hex[{idx, 2'b00} +: 4] = s_hex;
    commit_pt[idx] = s_p;
    commit_le[idx] = s_le;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_hex <= 16'd0;
      stage_pt  <= 4'd0;
      stage_le  <= 4'd0;
    end else if (store) begin
      stage_hex <= commit_hex;
      stage_pt  <= commit_pt;
      stage_le  <= commit_le;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hexout_frame <= 16'd0;
      point_frame  <= 4'd0;
      le_frame     <= 4'd0;
      frame_valid  <= 1'b0;
      seq_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      seq_err <= err;
      if (complete) begin
        if (!frame_valid || frame_ready) begin
          hexout_frame <= commit_hex;
          point_frame  <= commit_pt;
          le_frame     <= commit_le;
          frame_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_capture.sv
// Self-checking bench: drives digit dwells and compares every cycle against a
// dwell-level reference model of frame capture and handshake.
module tb_display_scan_capture;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  AN;
  logic [3:0]  Hexout;
  logic        LE;
  logic        p;
  logic        frame_ready;
  logic [15:0] hexout_frame;
  logic [3:0]  point_frame;
  logic [3:0]  le_frame;
  logic        frame_valid;
  logic        seq_err;
  logic        overrun;

  display_scan_capture #(.STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .AN           (AN),
    .Hexout       (Hexout),
    .LE           (LE),
    .p            (p),
    .frame_ready  (frame_ready),
    .hexout_frame (hexout_frame),
    .point_frame  (point_frame),
    .le_frame     (le_frame),
    .frame_valid  (frame_valid),
    .seq_err      (seq_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [3:0] an;
    logic [3:0] hex;
    logic       le;
    logic       p;
  } acc_t;

  acc_t        pend[$];
  int          compared = 0;
  int          mismatched = 0;
  int          edge_cnt = 0;
  int          ready_mode = 1;
  int          valid_cycles = 0;
  int          err_pulses = 0;
  logic [9:0]  prev_val = 10'd0;
  bit          prev_valid = 1'b0;

  int          m_have = 0;
  logic [3:0]  m_hex[4];
  logic        m_le[4];
  logic        m_p[4];
  logic [15:0] e_hex = 16'd0;
  logic [3:0]  e_pt = 4'd0;
  logic [3:0]  e_le = 4'd0;
  logic        e_valid = 1'b0;
  logic        e_err = 1'b0;
  logic        e_ovr = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_cnt, got, want);
    end
  endtask

  function automatic int digit_of(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      4'b1111: return -1;
      default: return -2;
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    m_have  = 0;
    e_hex   = 16'd0;
    e_pt    = 4'd0;
    e_le    = 4'd0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_ovr   = 1'b0;
  endtask

  // m_have counts in-order digits of the frame being collected (0 = hunting).
  task automatic model_update(input int e);
    acc_t a;
    int   d;
    bit   done;
    e_err = 1'b0;
    done  = 1'b0;
    if (pend.size() > 0 && pend[0].edge_no == e) begin
      a = pend.pop_front();
      d = digit_of(a.an);
      if (d == -2) begin
        e_err  = 1'b1;
        m_have = 0;
      end else if (d >= 0) begin
        if (d == m_have) begin
          m_hex[d] = a.hex; m_le[d] = a.le; m_p[d] = a.p;
          m_have++;
          if (m_have == 4) begin
            done   = 1'b1;
            m_have = 0;
          end
        end else if (m_have != 0) begin
          e_err = 1'b1;
          if (d == 0) begin
            m_hex[0] = a.hex; m_le[0] = a.le; m_p[0] = a.p;
            m_have = 1;
          end else begin
            m_have = 0;
          end
        end
      end
    end
    if (done) begin
      if (!e_valid || frame_ready) begin
        for (int i = 0; i < 4; i++) begin
          e_hex[4*i +: 4] = m_hex[i];
          e_pt[i] = m_p[i];
          e_le[i] = m_le[i];
        end
        e_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (e_valid && frame_ready) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic step_cycle();
    case (ready_mode)
      0: frame_ready = 1'b0;
      1: frame_ready = 1'b1;
      2: frame_ready = (pend.size() > 0 && pend[0].edge_no == edge_cnt + 1 && pend[0].an == 4'b0111);
      default: frame_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    edge_cnt++;
    #1;
    model_update(edge_cnt);
    if (frame_valid === 1'b1) valid_cycles++;
    if (seq_err === 1'b1) err_pulses++;
    check_output("hexout_frame", 32'(hexout_frame), 32'(e_hex));
    check_output("point_frame", 32'(point_frame), 32'(e_pt));
    check_output("le_frame", 32'(le_frame), 32'(e_le));
    check_output("frame_valid", 32'(frame_valid), 32'(e_valid));
    check_output("seq_err", 32'(seq_err), 32'(e_err));
    check_output("overrun", 32'(overrun), 32'(e_ovr));
  endtask

  // A dwell long enough to be accepted is applied on edge start+SC, where
  // start is the first edge that samples it.
  task automatic apply_stimulus(input logic [3:0] an, input logic [3:0] hex,
                                input logic le, input logic pb, input int len);
    logic [9:0] v;
    acc_t       a;
    v = {an, hex, le, pb};
    if (prev_valid && v == prev_val) v[0] = ~v[0];
    prev_val   = v;
    prev_valid = 1'b1;
    {AN, Hexout, LE, p} = v;
    if (len >= SC) begin
      a.edge_no = edge_cnt + 1 + SC;
      a.an  = v[9:6];
      a.hex = v[5:2];
      a.le  = v[1];
      a.p   = v[0];
      pend.push_back(a);
    end
    repeat (len) step_cycle();
  endtask

  task automatic blank_dwell(input int len);
    logic [3:0] h;
    h = prev_val[5:2] + 4'd1;
    apply_stimulus(4'b1111, h, 1'b0, 1'b0, len);
  endtask

  task automatic scan_digit(input int i, input logic [15:0] hx, input logic [3:0] pt,
                            input logic [3:0] le, input int len);
    logic [3:0] code;
    code = 4'b0001 << i;
    code = ~code;
    apply_stimulus(code, hx[4*i +: 4], le[i], pt[i], len);
  endtask

  task automatic scan_frame(input logic [15:0] hx, input logic [3:0] pt,
                            input logic [3:0] le, input int len);
    for (int i = 0; i < 4; i++) scan_digit(i, hx, pt, le, len);
  endtask

  task automatic begin_phase();
    valid_cycles = 0;
    err_pulses   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_hex"}, 32'(hexout_frame), 32'd0);
    check_output({tag, "_pt"}, 32'(point_frame), 32'd0);
    check_output({tag, "_le"}, 32'(le_frame), 32'd0);
    check_output({tag, "_valid"}, 32'(frame_valid), 32'd0);
    check_output({tag, "_err"}, 32'(seq_err), 32'd0);
    check_output({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
    rst_n      = 1'b1;
    prev_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {AN, Hexout, LE, p} = {4'b1111, 4'd0, 1'b0, 1'b0};
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // Clean scan with a consumer that is always ready.
    ready_mode = 1;
    blank_dwell(6);
    begin_phase();
    scan_frame(16'h1234, 4'b0101, 4'b0011, 8);
    blank_dwell(8);
    check_output("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check_output("t1_err_pulses", 32'(err_pulses), 32'd0);
    check_output("t1_hex", 32'(hexout_frame), 32'h1234);
    check_output("t1_pt", 32'(point_frame), 32'b0101);
    check_output("t1_le", 32'(le_frame), 32'b0011);

    // Dwells one cycle short of the stability window are invisible.
    begin_phase();
    scan_frame(16'h1234, 4'b0101, 4'b0011, SC - 1);
    blank_dwell(8);
    check_output("t2_valid_cycles", 32'(valid_cycles), 32'd0);
    check_output("t2_err_pulses", 32'(err_pulses), 32'd0);

    // Skipped digit, then a clean frame.
    begin_phase();
    scan_digit(0, 16'h9876, 4'b0000, 4'b0000, 8);
    scan_digit(1, 16'h9876, 4'b0000, 4'b0000, 8);
    scan_digit(3, 16'h9876, 4'b0000, 4'b0000, 8);
    blank_dwell(6);
    scan_frame(16'hABCD, 4'b1010, 4'b0110, 8);
    blank_dwell(6);
    check_output("t3_err_pulses", 32'(err_pulses), 32'd1);
    check_output("t3_valid_cycles", 32'(valid_cycles), 32'd1);
    check_output("t3_hex", 32'(hexout_frame), 32'hABCD);

    // Illegal select mid-frame discards the partial frame.
    begin_phase();
    scan_digit(0, 16'h4321, 4'b1111, 4'b1111, 8);
    scan_digit(1, 16'h4321, 4'b1111, 4'b1111, 8);
    apply_stimulus(4'b1100, 4'h7, 1'b1, 1'b1, 6);
    scan_digit(2, 16'h4321, 4'b1111, 4'b1111, 8);
    scan_digit(3, 16'h4321, 4'b1111, 4'b1111, 8);
    blank_dwell(6);
    check_output("t4_err_pulses", 32'(err_pulses), 32'd1);
    check_output("t4_valid_cycles", 32'(valid_cycles), 32'd0);

    // Blank gaps between digits are ignored.
    begin_phase();
    for (int i = 0; i < 4; i++) begin
      scan_digit(i, 16'h0F5A, 4'b1001, 4'b1100, 7);
      blank_dwell(5);
    end
    check_output("t4b_valid_cycles", 32'(valid_cycles), 32'd1);
    check_output("t4b_err_pulses", 32'(err_pulses), 32'd0);
    check_output("t4b_hex", 32'(hexout_frame), 32'h0F5A);

    // Stalled consumer: second frame dropped, then ready only on the commit cycle.
    ready_mode = 0;
    scan_frame(16'h1111, 4'b0001, 4'b0010, 8);
    scan_frame(16'h2222, 4'b0100, 4'b1000, 8);
    blank_dwell(6);
    check_output("t5_hex_kept", 32'(hexout_frame), 32'h1111);
    check_output("t5_overrun", 32'(overrun), 32'd1);
    check_output("t5_valid", 32'(frame_valid), 32'd1);
    ready_mode = 2;
    scan_frame(16'h3333, 4'b0110, 4'b0101, 8);
    blank_dwell(6);
    check_output("t5_hex_new", 32'(hexout_frame), 32'h3333);
    check_output("t5_valid_held", 32'(frame_valid), 32'd1);
    ready_mode = 1;
    blank_dwell(6);

    // Reset after digit 2, then a fresh frame.
    scan_digit(0, 16'h9ABC, 4'b0011, 4'b0011, 8);
    scan_digit(1, 16'h9ABC, 4'b0011, 4'b0011, 8);
    scan_digit(2, 16'h9ABC, 4'b0011, 4'b0011, 8);
    do_reset();
    begin_phase();
    scan_frame(16'h5678, 4'b1100, 4'b1010, 8);
    blank_dwell(6);
    check_output("t6_err_pulses", 32'(err_pulses), 32'd0);
    check_output("t6_valid_cycles", 32'(valid_cycles), 32'd1);
    check_output("t6_hex", 32'(hexout_frame), 32'h5678);
    check_output("t6_overrun", 32'(overrun), 32'd0);

    // Randomized dwells, select codes and consumer readiness.
    ready_mode = 3;
    begin
      int pos;
      pos = 0;
      for (int n = 0; n < 200; n++) begin
        int         r;
        int         len;
        logic [3:0] code;
        logic [3:0] one;
        r = int'($urandom_range(0, 99));
        if (r < 72) begin
          one  = 4'b0001 << pos;
          code = ~one;
          pos  = (pos + 1) % 4;
        end else if (r < 84) begin
          one  = 4'b0001 << $urandom_range(0, 3);
          code = ~one;
        end else if (r < 92) begin
          code = 4'b1111;
        end else begin
          code = 4'($urandom_range(0, 15));
          if (digit_of(code) != -2) code = 4'b0000;
        end
        len = (int'($urandom_range(0, 9)) < 2) ? int'($urandom_range(1, SC - 1))
                                               : int'($urandom_range(SC, SC + 4));
        apply_stimulus(code, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), len);
      end
    end
    blank_dwell(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
